// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, LSB first.
// One full-subtractor cell plus a registered borrow. The operation is
// requested with start, reported with a one-cycle done pulse, and the
// result is held in output registers until the next completion.
// Optional feature: define SERIAL_SUB_OVF_EN to add the signed-overflow
// output ovf.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    // Counter indexes bits 0..WIDTH-1.
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q,  state_d;
    logic [WIDTH-1:0]  a_q,      a_d;      // minuend shift register
    logic [WIDTH-1:0]  b_q,      b_d;      // subtrahend shift register
    logic [WIDTH-1:0]  res_q,    res_d;    // result assembled MSB-first
    logic              br_q,     br_d;     // running borrow
    logic [CNT_W-1:0]  cnt_q,    cnt_d;    // bit index
    logic [WIDTH-1:0]  diff_q,   diff_d;   // held result
    logic              borrow_q, borrow_d; // held final borrow

`ifdef SERIAL_SUB_OVF_EN
    logic              a_msb_q,  a_msb_d;  // operand sign bits, captured at accept
    logic              b_msb_q,  b_msb_d;
    logic              ovf_q,    ovf_d;
`endif

    // Full-subtractor cell working on the current LSBs.
    logic a0, b0, d_bit, br_next;
    logic [WIDTH-1:0] res_shifted;

    // Difference and borrow for the bit currently at the bottom of the shifters.
    always_comb begin
        a0          = a_q[0];
        b0          = b_q[0];
        d_bit       = a0 ^ b0 ^ br_q;
        br_next     = (~a0 & b0) | (~(a0 ^ b0) & br_q);
        res_shifted = {d_bit, res_q[WIDTH-1:1]};
    end

    // Next-state and datapath update for the IDLE/RUN/DONE sequence.
    always_comb begin
        // NOTE: every target gets a hold default first so no path through the
        // case leaves a variable unassigned, which would infer a latch.
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    res_d   = '0;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
`endif
                end
            end

            ST_RUN: begin
                res_d = res_shifted;
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = br_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    // Last bit lands on this edge: publish the finished result.
                    state_d  = ST_DONE;
                    diff_d   = res_shifted;
                    borrow_d = br_next;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d    = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
`endif
                end
            end

            ST_DONE: begin
                // start is deliberately ignored here; accept only from IDLE.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the values
        // from before this edge, independent of statement order.
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    // Handshake outputs decode the state; result outputs come straight from flops.
    always_comb begin
        busy   = (state_q != ST_IDLE);
        done   = (state_q == ST_DONE);
        diff   = diff_q;
        borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf    = ovf_q;
`endif
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned subtractor. Computes `diff = a - b` one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow. It is the sequential counterpart of the team's combinational half-adder and adder cells. It sits beside the serial adder datapath as a low-area arithmetic unit with a start/done handshake.

## Interface
Parameters:
- `WIDTH`, default 8, operand and result width in bits (legal values are 2 to 32).

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  synchronous reset, active-high.
- `start`  input  1  request a subtraction; sampled only in IDLE.
- `a`  input  WIDTH  minuend; captured on the accepting edge.
- `b`  input  WIDTH  subtrahend; captured on the accepting edge.
- `busy`  output  1  high whenever the state is not IDLE.
- `done`  output  1  one-cycle pulse; `diff`/`borrow` are valid from this cycle onward.
- `diff`  output  WIDTH  result `a - b` mod 2^WIDTH.
- `borrow`  output  1  final borrow out; 1 iff `a < b` (unsigned).
- `ovf`  output  1  signed overflow; present only with `SERIAL_SUB_OVF_EN`.

## Operation
- FSM with three states: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - `start`=1 → capture `a` and `b` into shift registers, clear the internal borrow register, clear the bit counter, and go to RUN.
  - `start`=0 → stay in IDLE.
- RUN, each cycle:
  - `a0` = LSB of the `a` shift register, `b0` = LSB of the `b` shift register, `br` = borrow register.
  - Difference bit `d = a0 ^ b0 ^ br`.
  - Next borrow `br' = (~a0 & b0) | (~(a0 ^ b0) & br)`.
  - Shift `d` into the MSB of the result shift register. Shift both operand registers right by one. Increment the counter.
  - When the counter reaches WIDTH-1 (the last bit is processed on this edge), go to DONE. On that same edge, load `diff` from the completed result and `borrow` from `br'`.
- DONE: `done`=1 for exactly this cycle. The next edge returns to IDLE unconditionally.
- `start` is ignored while `busy`=1, including in DONE. A new request is accepted only once the block is back in IDLE.
- `diff`, `borrow` (and `ovf`) are output registers. They hold their value until the next completion and do not change during RUN.
- Operands are captured, so `a` and `b` may change freely after the accepting edge.
- Boundary cases:
  - `a == b` → `diff`=0, `borrow`=0.
  - `a=0, b=2^WIDTH-1` → `diff`=1, `borrow`=1.
  - `a - 0` → `diff`=`a`, `borrow`=0.
- Reset, in any state including mid-RUN: the next edge enters IDLE. All outputs and internal registers become 0. No `done` pulse is produced for an aborted operation.

## Timing
- Reset values: `busy`=0, `done`=0, `diff`=0, `borrow`=0, `ovf`=0.
- Let edge E0 be the edge that samples `start`=1 in IDLE:
  - RUN occupies the cycles after edges E0 through E(WIDTH-1).
  - The result registers update on edge E(WIDTH). DONE is entered on the same edge.
  - `done` is high in the cycle after edge E(WIDTH).
  - Edge E(WIDTH+1) returns the FSM to IDLE.
- Throughput: one operation per WIDTH+2 cycles. The earliest next accepting edge is E(WIDTH+2), for `start` held high continuously.
- `busy` rises in the cycle after E0 and falls in the cycle after E(WIDTH+1).

## Configuration
- Macro `SERIAL_SUB_OVF_EN`.
- Defined:
  - Port `ovf` exists.
  - On the completion edge, `ovf` is loaded with `(a_msb != b_msb) && (diff_msb != a_msb)`, using the captured operand MSBs.
  - `ovf` is cleared by reset and held like `diff`.
- Undefined: no `ovf` port and no associated logic. All other behaviour is identical.

## Test plan
- WIDTH=8, `a`=200, `b`=55, pulse `start` → `done` pulses 9 cycles after the sampling edge; `diff`=145, `borrow`=0, `busy` low afterwards.
- `a`=55, `b`=200 → `diff`=0x6F (111), `borrow`=1. Then `a`=0, `b`=1 → `diff`=0xFF, `borrow`=1. Then `a`=0x5A, `b`=0x5A → `diff`=0, `borrow`=0.
- Assert `start` with `a`=9, `b`=4 during RUN of an operation computing 10-3 → the result is 7, only one `done` pulse occurs, and the second request is dropped.
- Hold `start`=1 continuously with fixed operands → `done` pulses every WIDTH+2 = 10 cycles, and `diff` is stable between pulses.
- Assert `rst` for one cycle at the 4th RUN cycle of 100-30 → all outputs read 0 after the edge, no `done` appears, and a following 100-30 request yields 70.
- With `SERIAL_SUB_OVF_EN`:
  - 0x80-0x01 → `diff`=0x7F, `ovf`=1.
  - 0x7F-0xFF → `diff`=0x80, `ovf`=1.
  - 0x10-0x05 → `ovf`=0.
